// File: rtl/reg_write_scoreboard_pkg.sv
// Shared register-file constants and types for the issue-stage write scoreboard.
package reg_write_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/reg_write_scoreboard_if.sv
// Issue/write-back bus between the decode/issue stage and the write scoreboard.
interface reg_write_scoreboard_if;
  import reg_write_scoreboard_pkg::*;

  logic                issue_valid;
  logic                issue_rd_enb;
  reg_addr_t           issue_rd_addr;
  reg_addr_t           issue_rs1_addr;
  logic                issue_rs1_used;
  reg_addr_t           issue_rs2_addr;
  logic                issue_rs2_used;
  logic                issue_stall;
  logic                issue_fire;
  logic                wb_valid;
  reg_addr_t           wb_addr;
  logic                flush;
  logic [NUM_REGS-1:0] busy_mask;
  logic                err_underflow;

  modport master (
    output issue_valid, issue_rd_enb, issue_rd_addr,
    output issue_rs1_addr, issue_rs1_used, issue_rs2_addr, issue_rs2_used,
    output wb_valid, wb_addr, flush,
    input  issue_stall, issue_fire, busy_mask, err_underflow
  );

  modport slave (
    input  issue_valid, issue_rd_enb, issue_rd_addr,
    input  issue_rs1_addr, issue_rs1_used, issue_rs2_addr, issue_rs2_used,
    input  wb_valid, wb_addr, flush,
    output issue_stall, issue_fire, busy_mask, err_underflow
  );

endinterface

// File: rtl/reg_write_scoreboard_sb_counter.sv
// One per-register pending-write counter: up on issue, down on write-back, clear on flush.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturate at both ends; simultaneous inc and dec cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  assign nonzero = |cnt;

endmodule

// File: rtl/reg_write_scoreboard.sv
// Issue-stage scoreboard: counts outstanding writes per register and stalls
// issue of instructions that read a register whose value is still in flight.
module reg_write_scoreboard
  import reg_write_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_write_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nz;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] src_busy;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic                rd_sat;
  logic                stall_cond;
  logic                fire;
  logic                underflow;
  logic                err_q;

  genvar r;
  generate
    for (r = 0; r < NUM_REGS; r++) begin : g_reg
      if (r == 0) begin : g_x0
        assign cnt[r] = '0;
        assign nz[r]  = 1'b0;
      end else begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
          .clk     (clk),
          .rst     (rst),
          .inc     (inc[r]),
          .dec     (dec[r]),
          .clr     (bus.flush),
          .cnt     (cnt[r]),
          .nonzero (nz[r])
        );
      end
    end
  endgenerate

  // A write-back retiring the last outstanding write releases readers in the same cycle.
  always_comb begin
    wb_hit   = '0;
    src_busy = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wb_hit[i]   = bus.wb_valid && (bus.wb_addr == REG_ADDR_W'(i));
      src_busy[i] = nz[i] && !(wb_hit[i] && cnt[i] == CNT_ONE);
    end
  end

  // A full counter blocks a further write to that register unless one retires now.
  assign rd_sat = bus.issue_rd_enb && (bus.issue_rd_addr != X0) &&
                  (cnt[bus.issue_rd_addr] == CNT_MAX) && !wb_hit[bus.issue_rd_addr];

  assign stall_cond = (bus.issue_rs1_used && src_busy[bus.issue_rs1_addr]) ||
                      (bus.issue_rs2_used && src_busy[bus.issue_rs2_addr]) ||
                      rd_sat;

  assign fire            = bus.issue_valid && !stall_cond;
  assign bus.issue_stall = bus.issue_valid && stall_cond;
  assign bus.issue_fire  = fire;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc[i] = fire && bus.issue_rd_enb && (bus.issue_rd_addr == REG_ADDR_W'(i));
      dec[i] = wb_hit[i] && nz[i];
    end
  end

  // Write-back to an idle register is a pipeline bookkeeping error; a flush cycle is exempt.
  assign underflow = bus.wb_valid && (bus.wb_addr != X0) && !nz[bus.wb_addr] && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (underflow) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_underflow = err_q;
  assign bus.busy_mask     = nz;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench for reg_write_scoreboard: the driver queues hand-computed expectations,
// a negedge monitor pops one per cycle and compares against the DUT outputs.
module tb_reg_write_scoreboard;
  import reg_write_scoreboard_pkg::*;

  typedef struct {
    string       name;
    logic        stall;
    logic        fire;
    logic [31:0] mask;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t q[$];

  reg_write_scoreboard_if bus();

  reg_write_scoreboard #(.CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] bit_of(input int n);
    logic [31:0] v;
    v = 32'h1 << n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".stall"}, 32'(bus.issue_stall),   32'(e.stall));
      chk({e.name, ".fire"},  32'(bus.issue_fire),    32'(e.fire));
      chk({e.name, ".mask"},  bus.busy_mask,          e.mask);
      chk({e.name, ".err"},   32'(bus.err_underflow), 32'(e.err));
    end
  end

  task automatic drive(input logic v, input logic rde, input int rd,
                       input logic u1, input int rs1, input logic u2, input int rs2,
                       input logic wbv, input int wba, input logic fl);
    bus.issue_valid    = v;
    bus.issue_rd_enb   = rde;
    bus.issue_rd_addr  = REG_ADDR_W'(rd);
    bus.issue_rs1_used = u1;
    bus.issue_rs1_addr = REG_ADDR_W'(rs1);
    bus.issue_rs2_used = u2;
    bus.issue_rs2_addr = REG_ADDR_W'(rs2);
    bus.wb_valid       = wbv;
    bus.wb_addr        = REG_ADDR_W'(wba);
    bus.flush          = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_step(input string name, input logic st, input logic fi,
                             input logic [31:0] m, input logic er);
    exp_t e;
    e.name = name; e.stall = st; e.fire = fi; e.mask = m; e.err = er;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    @(posedge clk);
    #1;
    expect_step("reset", 0, 0, 32'h0, 0);
    rst = 1'b0;

    // RAW on x5 with same-cycle write-back bypass
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); expect_step("iss_rd5",    0, 1, 32'h0,     0);
    drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0); expect_step("raw_rs1_5",  1, 0, bit_of(5), 0);
    drive(1, 0, 0, 1, 5, 0, 0, 1, 5, 0); expect_step("raw_bypass", 0, 1, bit_of(5), 0);
    idle();                              expect_step("x5_free",    0, 0, 32'h0,     0);

    // x0 is never tracked
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); expect_step("iss_rd0", 0, 1, 32'h0, 0);
    end
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0, 0); expect_step("read_x0", 0, 1, 32'h0, 0);

    // Counter saturation on x7
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); expect_step("x7_a", 0, 1, 32'h0,     0);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); expect_step("x7_b", 0, 1, bit_of(7), 0);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); expect_step("x7_c", 0, 1, bit_of(7), 0);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); expect_step("x7_sat",     1, 0, bit_of(7), 0);
    drive(1, 1, 7, 0, 0, 0, 0, 1, 7, 0); expect_step("x7_sat_wb",  0, 1, bit_of(7), 0);
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); expect_step("x7_still3",  1, 0, bit_of(7), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); expect_step("x7_wb3",     0, 0, bit_of(7), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); expect_step("x7_wb2",     0, 0, bit_of(7), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); expect_step("x7_wb1",     0, 0, bit_of(7), 0);
    idle();                              expect_step("x7_empty",   0, 0, 32'h0,     0);

    // Simultaneous issue and write-back on x9 leaves count at 1
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0); expect_step("x9_iss",    0, 1, 32'h0,     0);
    drive(1, 1, 9, 0, 0, 0, 0, 1, 9, 0); expect_step("x9_iss_wb", 0, 1, bit_of(9), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); expect_step("x9_one",    0, 0, bit_of(9), 0);
    idle();                              expect_step("x9_empty",  0, 0, 32'h0,     0);

    // Write-back to idle register during flush is not an underflow
    drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 1); expect_step("flush_wb12", 0, 0, 32'h0, 0);
    idle();                               expect_step("no_uf",      0, 0, 32'h0, 0);

    // Sticky underflow
    drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0); expect_step("uf_wb12", 0, 0, 32'h0, 0);
    idle();                               expect_step("uf_set",  0, 0, 32'h0, 1);
    idle();                               expect_step("uf_hold", 0, 0, 32'h0, 1);

    // Flush discards in-flight tracking, including a same-cycle issue
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); expect_step("x3_a", 0, 1, 32'h0,     1);
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); expect_step("x3_b", 0, 1, bit_of(3), 1);
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); expect_step("x4_a", 0, 1, bit_of(3), 1);
    drive(1, 0, 0, 1, 4, 0, 0, 0, 0, 1); expect_step("flush_stall", 1, 0, bit_of(3) | bit_of(4), 1);
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 1); expect_step("flush_iss3",  0, 1, 32'h0, 1);
    idle();                              expect_step("flushed",     0, 0, 32'h0, 1);

    // Asynchronous reset mid-cycle
    drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0); expect_step("x6_iss", 0, 1, 32'h0, 1);
    idle();
    begin
      exp_t e;
      e.name = "x6_busy"; e.stall = 0; e.fire = 0; e.mask = bit_of(6); e.err = 1;
      q.push_back(e);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.mask", bus.busy_mask, 32'h0);
    chk("async_rst.err",  32'(bus.err_underflow), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
